// File: rtl/ahb_si_resp_mux_pipe.sv
// Master-side AHB response mux: captures the one-hot slave select in the address phase
// and steers the selected slave's response in the data phase. A built-in default slave
// answers idle or no-slave cycles, and gives a two-cycle ERROR for bad active decodes.
module ahb_si_resp_mux_pipe #(
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  localparam int unsigned PAYLOAD    = DATA_WIDTH + 2
) (
  input  logic                                  HCLK,
  input  logic                                  HRESETn,
  input  logic [1:0]                            htrans_in,
  input  logic [CHANNEL_NUM-1:0]                sel_in,
  input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0]   payload_in,
  output logic [PAYLOAD-1:0]                    payload_out,
  output logic                                  hready_out,
  output logic [CHANNEL_NUM-1:0]                dsel_out,
  output logic                                  def_err_out
);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t             state;
  logic               active;
  logic               sel_onehot;
  logic [PAYLOAD-1:0] slave_mux;
  logic               unused_htrans;

  // Only NONSEQ/SEQ are real transfers; BUSY and IDLE never raise an error.
  assign active        = htrans_in[1];
  assign unused_htrans = htrans_in[0];
  assign sel_onehot    = (sel_in != '0) &&
                         ((sel_in & (sel_in - CHANNEL_NUM'(1))) == '0);

  // Address-phase capture; ERR1 always advances, even though HREADY is low there.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_OK;
      dsel_out <= '0;
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
    end else if (hready_out) begin
      if (sel_onehot) begin
        dsel_out <= sel_in;
        state    <= ST_OK;
      end else begin
        dsel_out <= '0;
        state    <= active ? ST_ERR1 : ST_OK;
      end
    end
  end

  // Data-phase mux; dsel_out is one-hot or zero, so an AND-OR tree is enough.
  always_comb begin
    slave_mux = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      slave_mux = slave_mux | (payload_in[i] & {PAYLOAD{dsel_out[i]}});
    end

    payload_out = {DATA_WIDTH'(0), 1'b1, 1'b0};
    case (state)
      ST_ERR1: payload_out = {DATA_WIDTH'(0), 1'b0, 1'b1};
      ST_ERR2: payload_out = {DATA_WIDTH'(0), 1'b1, 1'b1};
      default: begin
        if (dsel_out != '0) begin
          payload_out = slave_mux;
        end
      end
    endcase
  end

  assign hready_out  = payload_out[1];
  assign def_err_out = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_si_resp_mux_pipe.sv
// Scoreboard bench for ahb_si_resp_mux_pipe: each driven cycle pushes its expected
// data-phase response, which the negedge monitor pops and compares.
module tb_ahb_si_resp_mux_pipe;

  localparam int unsigned CH  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned PAY = DW + 2;

  logic                       HCLK = 1'b0;
  logic                       HRESETn;
  logic [1:0]                 htrans_in;
  logic [CH-1:0]              sel_in;
  logic [CH-1:0][PAY-1:0]     payload_in;
  logic [PAY-1:0]             payload_out;
  logic                       hready_out;
  logic [CH-1:0]              dsel_out;
  logic                       def_err_out;

  typedef struct packed {
    logic [PAY-1:0] p;
    logic [CH-1:0]  dsel;
    logic           err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_st     = 0;   // 0 OK, 1 ERR1, 2 ERR2
  logic [CH-1:0] m_dsel   = '0;

  always #5 HCLK = ~HCLK;

  ahb_si_resp_mux_pipe #(
    .CHANNEL_NUM (CH),
    .DATA_WIDTH  (DW)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .htrans_in   (htrans_in),
    .sel_in      (sel_in),
    .payload_in  (payload_in),
    .payload_out (payload_out),
    .hready_out  (hready_out),
    .dsel_out    (dsel_out),
    .def_err_out (def_err_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, predict its data-phase output, then advance the model state.
  task automatic step(input logic rst, input logic [1:0] tr, input logic [CH-1:0] sel,
                      input logic [CH-1:0] rdy, input logic [CH-1:0] rsp,
                      input logic [DW-1:0] d1 = '0);
    exp_t           e;
    logic [PAY-1:0] ep;
    int             cnt;
    @(posedge HCLK);
    #1;
    HRESETn   = rst;
    htrans_in = tr;
    sel_in    = sel;
    for (int i = 0; i < int'(CH); i++) begin
      payload_in[i] = {DW'($urandom), rdy[i], rsp[i]};
    end
    if (d1 != '0) payload_in[1][PAY-1:2] = d1;

    case (m_st)
      1: ep = {DW'(0), 1'b0, 1'b1};
      2: ep = {DW'(0), 1'b1, 1'b1};
      default: begin
        ep = {DW'(0), 1'b1, 1'b0};
        for (int i = 0; i < int'(CH); i++) begin
          if (m_dsel[i]) ep = payload_in[i];
        end
      end
    endcase
    e.p    = ep;
    e.dsel = m_dsel;
    e.err  = (m_st != 0);
    sb.push_back(e);

    if (!rst) begin
      m_st   = 0;
      m_dsel = '0;
    end else if (m_st == 1) begin
      m_st = 2;
    end else if (ep[1]) begin
      cnt = $countones(sel);
      if (cnt == 1) begin
        m_dsel = sel;
        m_st   = 0;
      end else begin
        m_dsel = '0;
        m_st   = tr[1] ? 1 : 0;
      end
    end
  endtask

  always @(negedge HCLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("payload", 64'(payload_out), 64'(mon_e.p));
      check("hready",  64'(hready_out),  64'(mon_e.p[1]));
      check("dsel",    64'(dsel_out),    64'(mon_e.dsel));
      check("def_err", 64'(def_err_out), 64'(mon_e.err));
    end
  end

  initial begin
    logic [1:0]    r_tr;
    logic [CH-1:0] r_sel, r_rdy, r_rsp;
    logic          r_rst;
    int            pick;

    HRESETn    = 1'b0;
    htrans_in  = 2'b00;
    sel_in     = '0;
    payload_in = '0;

    // reset then idle
    step(1'b0, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b0, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // single read from slave 1
    step(1'b1, 2'b10, 3'b010, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000, 32'hA5A5_0001);

    // slave 2 stalls three cycles while the next select changes underneath
    step(1'b1, 2'b10, 3'b100, 3'b111, 3'b000);
    repeat (3) step(1'b1, 2'b11, 3'b001, 3'b011, 3'b000);
    step(1'b1, 2'b11, 3'b001, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // no-slave error; the ERR1 cycle must ignore its address phase
    step(1'b1, 2'b10, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b10, 3'b010, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // multi-hot active, back-to-back error, then multi-hot idle/busy
    step(1'b1, 2'b11, 3'b011, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b11, 3'b011, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b011, 3'b111, 3'b000);
    step(1'b1, 2'b01, 3'b011, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // reset during ERR1
    step(1'b1, 2'b10, 3'b000, 3'b111, 3'b000);
    step(1'b0, 2'b00, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // reset during a slave wait state
    step(1'b1, 2'b10, 3'b001, 3'b111, 3'b000);
    step(1'b0, 2'b00, 3'b000, 3'b110, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b000);

    // slave ERROR response passes straight through
    step(1'b1, 2'b10, 3'b001, 3'b111, 3'b000);
    step(1'b1, 2'b00, 3'b000, 3'b111, 3'b001);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r_tr = 2'($urandom);
      pick = $urandom_range(0, 3);
      if (pick == 0)      r_sel = '0;
      else if (pick == 3) r_sel = CH'($urandom);
      else                r_sel = CH'(1 << $urandom_range(0, CH - 1));
      for (int i = 0; i < int'(CH); i++) begin
        r_rdy[i] = ($urandom_range(0, 3) != 0);
        r_rsp[i] = ($urandom_range(0, 4) == 0);
      end
      r_rst = ($urandom_range(0, 49) != 0);
      step(r_rst, r_tr, r_sel, r_rdy, r_rsp);
    end

    @(posedge HCLK);
    @(negedge HCLK);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_si_resp_mux_pipe.md
Name: ahb_si_resp_mux_pipe

Overview:
Master-side AHB response mux. Selects one of CHANNEL_NUM slave response payloads (HRDATA/HREADYOUT/HRESP) for one master. The one-hot slave select is captured in the address phase and applied in the data phase. A built-in default slave returns zero-wait OKAY for idle or no-slave cycles and a two-cycle ERROR for active transfers that decode to no slave or to more than one slave. Sits between the slave-side decoder and the master port of the interconnect.

Parameters:
CHANNEL_NUM, 3, number of slave channels (1..32).
DATA_WIDTH, 32, HRDATA width (32/64/128).
PAYLOAD, DATA_WIDTH+2, derived localparam. Field layout: [PAYLOAD-1:2]=hrdata, [1]=hreadyout, [0]=hresp.

Ports:
HCLK  in  1  clock, all state on rising edge.
HRESETn  in  1  synchronous active-low reset.
htrans_in  in  2  address-phase HTRANS of the master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
sel_in  in  CHANNEL_NUM  address-phase one-hot slave decode.
payload_in  in  CHANNEL_NUM x PAYLOAD  packed slave responses, index i = slave i.
payload_out  out  PAYLOAD  muxed response to the master.
hready_out  out  1  copy of payload_out[1]; the bus HREADY.
dsel_out  out  CHANNEL_NUM  registered data-phase select; also used as the HSEL qualifier for slave HREADY.
def_err_out  out  1  high while the default slave drives ERROR.

Behaviour:
- Capture edge: rising HCLK with hready_out==1. Only capture edges update dsel_out and the FSM's OK-state decision. When hready_out==0, all state holds except the ERR1 to ERR2 step.
- Decode at a capture edge:
  - active = htrans_in[1].
  - sel_in exactly one-hot: dsel_out<=sel_in, state OK.
  - Otherwise, with active: dsel_out<=0, state ERR1.
  - Otherwise (not active, sel_in zero or multi-hot): dsel_out<=0, state OK.
  - BUSY and IDLE are never errors.
- FSM states:
  - OK: output is the selected slave payload, or the default zero-wait OKAY if dsel_out==0.
  - ERR1: output hrdata=0, hreadyout=0, hresp=1. Always moves to ERR2 on the next edge.
  - ERR2: output hrdata=0, hreadyout=1, hresp=1. Is a capture edge, so it decodes the next address phase.
- Output mux: combinational from dsel_out and state, so zero added latency in the data phase.
  - OK with dsel_out==0: hrdata=0, hreadyout=1, hresp=0.
  - Onehot dsel_out: payload_out = payload_in[index of set bit].
- def_err_out = (state==ERR1 || state==ERR2).
- Latency: sel_in at address-phase edge N drives payload_out from cycle N+1 until the slave raises hreadyout.
- Wait states: a selected slave holding hreadyout=0 stalls capture. dsel_out stays stable across the whole stall.
- Multi-hot sel_in during IDLE: no error. Zero OKAY, dsel_out=0.
- Back-to-back errors: ERR2 with a new bad active decode goes to ERR1 again.
- Reset: HRESETn low at an edge forces state=OK and dsel_out=0. This also applies mid-ERR or mid-wait, with no completion of the pending response.
  - Outputs the cycle after reset: payload_out={0,1'b1,1'b0}, hready_out=1, def_err_out=0, dsel_out=0.
- CHANNEL_NUM==1 is legal: sel_in==1 is the only valid decode.

Test Plan:
- Reset then idle: HRESETn=0 for 2 cycles, htrans=IDLE -> payload_out hrdata=0, hreadyout=1, hresp=0; dsel_out=0.
- Single read: NONSEQ, sel_in=3'b010; slave1 returns hrdata=0xA5A5_0001 with hreadyout=1 next cycle -> in that cycle payload_out hrdata=0xA5A5_0001, hresp=0, dsel_out=3'b010.
- Wait states: slave2 selected, hreadyout=0 for 3 cycles and sel_in changed to 3'b001 during the stall -> dsel_out stays 3'b100 for 3 cycles, then becomes 3'b001 only on the ready edge.
- No-slave error: NONSEQ with sel_in=0 -> next cycle hreadyout=0, hresp=1, def_err_out=1; the cycle after, hreadyout=1, hresp=1; then OK.
- Multi-hot: SEQ with sel_in=3'b011 -> two-cycle ERROR. IDLE with sel_in=3'b011 -> zero-wait OKAY, no def_err_out.
- Reset in ERR1: assert HRESETn=0 during ERR1 -> next cycle hreadyout=1, hresp=0, def_err_out=0, dsel_out=0.
